// File: rtl/simon_sequencer.sv
// Simon memory game sequencer: grows a random colour sequence, plays it back
// on a one-hot LED display and then checks the player's button presses.
module simon_sequencer #(
    parameter int MAX_LEN   = 16,
    parameter int ON_TICKS  = 4,
    parameter int GAP_TICKS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] rand_color,
    input  logic       tick,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [1:0] btn_color,
    output logic [3:0] led,
    output logic [4:0] round,
    output logic       await_input,
    output logic       game_over,
    output logic       win
);

    localparam int AW   = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
    localparam int TMAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_INPUT,
        S_FAIL,
        S_WIN
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      len_q, len_d;
    logic [4:0]      idx_q, idx_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [1:0]      mem_q [MAX_LEN];

    logic [1:0]      cur_color;
    logic            last_idx;

    assign cur_color = mem_q[idx_q[AW-1:0]];
    assign last_idx  = (idx_q == (len_q - 5'd1));

    // Next-state logic: sequence growth, timed playback and press checking.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = 5'd0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                len_d   = len_q + 5'd1;
                idx_d   = 5'd0;
                tcnt_d  = '0;
                state_d = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                if (tick) begin
                    if (tcnt_q == TW'(ON_TICKS - 1)) begin
                        tcnt_d  = '0;
                        state_d = S_SHOW_OFF;
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            S_SHOW_OFF: begin
                if (tick) begin
                    if (tcnt_q == TW'(GAP_TICKS - 1)) begin
                        tcnt_d = '0;
                        if (last_idx) begin
                            idx_d   = 5'd0;
                            state_d = S_INPUT;
                        end else begin
                            idx_d   = idx_q + 5'd1;
                            state_d = S_SHOW_ON;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            S_INPUT: begin
                if (btn_valid) begin
                    if (btn_color != cur_color) begin
                        state_d = S_FAIL;
                    end else if (!last_idx) begin
                        idx_d = idx_q + 5'd1;
                    end else if (len_q == 5'(MAX_LEN)) begin
                        state_d = S_WIN;
                    end else begin
                        state_d = S_ADD;
                    end
                end
            end
            S_FAIL, S_WIN: begin
                if (start) begin
                    len_d   = 5'd0;
                    state_d = S_ADD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control registers, cleared immediately when reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            len_q   <= 5'd0;
            idx_q   <= 5'd0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Sequence memory appends the sampled random colour in ADD; never reset.
    always_ff @(posedge clk) begin
        if (state_q == S_ADD) begin
            mem_q[len_q[AW-1:0]] <= rand_color;
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        led         = 4'b0000;
        await_input = 1'b0;
        game_over   = 1'b0;
        win         = 1'b0;
        round       = len_q;
        case (state_q)
            S_SHOW_ON: led = 4'b0001 << cur_color;
            S_INPUT:   await_input = 1'b1;
            S_FAIL: begin
                led       = 4'b1111;
                game_over = 1'b1;
            end
            S_WIN: begin
                led = 4'b1111;
                win = 1'b1;
            end
            default: led = 4'b0000;
        endcase
    end

endmodule

// File: tb/tb_simon_sequencer.sv
// Directed self-checking bench for simon_sequencer: a default-size instance
// and a MAX_LEN=2 instance share the same stimulus.
module tb_simon_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] rand_color = 2'd0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_color = 2'd0;

    logic [3:0] led_a, led_b;
    logic [4:0] round_a, round_b;
    logic       await_a, await_b;
    logic       over_a, over_b;
    logic       win_a, win_b;

    int tests = 0;
    int fails = 0;

    simon_sequencer dut (
        .clk(clk), .reset(reset), .rand_color(rand_color), .tick(tick),
        .start(start), .btn_valid(btn_valid), .btn_color(btn_color),
        .led(led_a), .round(round_a), .await_input(await_a),
        .game_over(over_a), .win(win_a)
    );

    simon_sequencer #(.MAX_LEN(2)) dut2 (
        .clk(clk), .reset(reset), .rand_color(rand_color), .tick(tick),
        .start(start), .btn_valid(btn_valid), .btn_color(btn_color),
        .led(led_b), .round(round_b), .await_input(await_b),
        .game_over(over_b), .win(win_b)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic give_tick();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        cycle();
    endtask

    task automatic press(input logic [1:0] c);
        btn_valid = 1'b1;
        btn_color = c;
        cycle();
        btn_valid = 1'b0;
    endtask

    // Walks one full playback of n colours (colour k in colors[2k+:2]).
    task automatic play(input logic [5:0] colors, input int n);
        for (int k = 0; k < n; k++) begin
            logic [3:0] onehot;
            onehot = 4'b0001 << colors[2*k +: 2];
            check("show led a", led_a, onehot);
            check("show led b", led_b, onehot);
            for (int t = 1; t <= 4; t++) begin
                give_tick();
                check("on led a", led_a, (t < 4) ? onehot : 4'b0000);
            end
            give_tick();
            check("gap led a", led_a, 4'b0000);
            check("gap await a", await_a, 1'b0);
            give_tick();
        end
        check("await a", await_a, 1'b1);
        check("await b", await_b, 1'b1);
        check("await led a", led_a, 4'b0000);
    endtask

    initial begin
        // Reset state.
        repeat (3) cycle();
        check("rst led", led_a, 4'b0000);
        check("rst round", round_a, 5'd0);
        check("rst await", await_a, 1'b0);
        check("rst over", over_a, 1'b0);
        check("rst win", win_a, 1'b0);
        reset = 1'b1;
        repeat (3) cycle();
        check("idle led", led_a, 4'b0000);
        check("idle round", round_a, 5'd0);

        // Game 1: first colour 2, tick coincident with the ADD->SHOW_ON edge.
        rand_color = 2'd2;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("add round", round_a, 5'd0);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        check("r1 round a", round_a, 5'd1);
        check("r1 led a", led_a, 4'b0100);
        press(2'd2);
        check("btn in show led", led_a, 4'b0100);
        check("btn in show await", await_a, 1'b0);
        play(6'b000010, 1);

        // Correct press grows the sequence with colour 3.
        rand_color = 2'd3;
        press(2'd2);
        check("press add await", await_a, 1'b0);
        check("press add round", round_a, 5'd1);
        cycle();
        check("r2 round a", round_a, 5'd2);
        check("r2 round b", round_b, 5'd2);
        play(6'b001110, 2);

        // Wrong first press at round 2.
        press(2'd0);
        check("fail over a", over_a, 1'b1);
        check("fail led a", led_a, 4'b1111);
        check("fail await a", await_a, 1'b0);
        check("fail win a", win_a, 1'b0);
        check("fail over b", over_b, 1'b1);

        // Game 2 from FAIL.
        rand_color = 2'd1;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("restart round", round_a, 5'd0);
        cycle();
        check("g2 round", round_a, 5'd1);
        play(6'b000001, 1);
        rand_color = 2'd0;
        press(2'd1);
        cycle();
        check("g2 r2 round a", round_a, 5'd2);
        check("g2 r2 round b", round_b, 5'd2);
        play(6'b000001, 2);
        press(2'd1);
        check("mid seq await", await_a, 1'b1);
        check("mid seq round", round_a, 5'd2);
        press(2'd0);
        check("win b", win_b, 1'b1);
        check("win led b", led_b, 4'b1111);
        check("win over b", over_b, 1'b0);
        check("win await b", await_b, 1'b0);
        check("no win a", win_a, 1'b0);
        check("add after r2 a", await_a, 1'b0);

        // Start restarts the winner; start is ignored by the instance in ADD.
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("r3 round a", round_a, 5'd3);
        check("r3 led a", led_a, 4'b0010);
        check("win restart round b", round_b, 5'd0);
        check("win restart win b", win_b, 1'b0);
        cycle();
        check("new game round b", round_b, 5'd1);
        check("new game led b", led_b, 4'b0001);

        // Asynchronous reset during SHOW_ON.
        #2;
        reset = 1'b0;
        #1;
        check("async led a", led_a, 4'b0000);
        check("async round a", round_a, 5'd0);
        check("async led b", led_b, 4'b0000);
        cycle();
        reset = 1'b1;
        repeat (2) cycle();
        check("post rst led", led_a, 4'b0000);
        check("post rst round", round_a, 5'd0);
        check("post rst await", await_a, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
